// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between the CPU controller
// and the program loader. Each access takes three cycles (IDLE, ISSUE, RESP).
// The CPU normally wins ties. The loader is guaranteed a turn after MAX_WAIT
// consecutive CPU grants made while it was waiting.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       gnt_ld;
    logic       any_req;
    logic       ld_wins;

    // The loader wins if it is the only requester, or if it has waited long enough.
    assign any_req = cpu_req | ld_req;
    assign ld_wins = ld_req & (~cpu_req | (wait_cnt >= WAIT_LIMIT));

    // Access sequencer. The grant, the memory strobes and the acks are all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            gnt_ld    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            ld_ack    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            ld_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ld_req || ld_wins) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt < WAIT_LIMIT) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                    if (any_req) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        gnt_ld    <= ld_wins;
                        mem_en    <= 1'b1;
                        mem_we    <= ld_wins ? ld_we : cpu_we;
                        mem_addr  <= ld_wins ? ld_addr : cpu_addr;
                        mem_wdata <= ld_wins ? ld_wdata : cpu_wdata;
                    end
                end
                ISSUE: begin
                    state   <= RESP;
                    cpu_ack <= ~gnt_ld;
                    ld_ack  <= gnt_ld;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read data passes straight through from memory during the winner's ack cycle only.
    always_comb begin
        cpu_rdata = cpu_ack ? mem_rdata : '0;
        ld_rdata  = ld_ack ? mem_rdata : '0;
        cpu_stall = cpu_req & ~cpu_ack;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed stimulus for mem_arbiter. The outputs
// are checked every cycle against a transaction-level timeline model.
module tb_mem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;
    localparam int MSZ      = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          ld_req = 1'b0;
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          ld_ack;
    logic [DW-1:0] ld_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous memory: read data appears the cycle after the strobe.
    logic [DW-1:0] phys_mem [MSZ];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) phys_mem[mem_addr[5:0]] <= mem_wdata;
            else        mem_rdata <= phys_mem[mem_addr[5:0]];
        end
    end

    // Reference model: the edge number of the last grant, and the access it carries.
    int            e_cnt = 0;
    int            g_edge = -100;
    int            waitc = 0;
    bit            g_ld = 1'b0;
    bit            g_we = 1'b0;
    logic [AW-1:0] g_addr = '0;
    logic [DW-1:0] g_wdata = '0;
    logic [DW-1:0] g_rdata = '0;
    logic [DW-1:0] ref_mem [MSZ];

    // Advance the model at each edge. A new grant is possible once two cycles have passed since the last one.
    always @(posedge clk or negedge rst_n) begin
        bit lw;
        if (!rst_n) begin
            g_edge  = -100;
            waitc   = 0;
            g_addr  = '0;
            g_wdata = '0;
            g_we    = 1'b0;
        end else begin
            e_cnt++;
            if (e_cnt - 1 == g_edge) begin
                if (g_we) ref_mem[g_addr[5:0]] = g_wdata;
                else      g_rdata = ref_mem[g_addr[5:0]];
            end
            if (e_cnt - 1 >= g_edge + 2) begin
                lw = ld_req && (!cpu_req || waitc >= MAX_WAIT);
                if (!ld_req || lw) waitc = 0;
                else waitc = (waitc + 1 > MAX_WAIT) ? MAX_WAIT : waitc + 1;
                if (cpu_req || ld_req) begin
                    g_edge  = e_cnt;
                    g_ld    = lw;
                    g_we    = lw ? ld_we : cpu_we;
                    g_addr  = lw ? ld_addr : cpu_addr;
                    g_wdata = lw ? ld_wdata : cpu_wdata;
                end
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        int ph;
        bit e_iss, e_cack, e_lack;
        if (chk_en) begin
            ph     = e_cnt - g_edge;
            e_iss  = (ph == 0);
            e_cack = (ph == 1) && !g_ld;
            e_lack = (ph == 1) && g_ld;
            check_output("mem_en", mem_en, e_iss);
            check_output("mem_we", mem_we, e_iss && g_we);
            check_output("mem_addr", mem_addr, g_addr);
            check_output("mem_wdata", mem_wdata, g_wdata);
            check_output("busy", busy, (ph == 0) || (ph == 1));
            check_output("cpu_ack", cpu_ack, e_cack);
            check_output("ld_ack", ld_ack, e_lack);
            check_output("cpu_stall", cpu_stall, cpu_req && !e_cack);
            if (!e_cack) check_output("cpu_rdata_idle", cpu_rdata, 0);
            else if (!g_we) check_output("cpu_rdata", cpu_rdata, g_rdata);
            if (!e_lack) check_output("ld_rdata_idle", ld_rdata, 0);
            else if (!g_we) check_output("ld_rdata", ld_rdata, g_rdata);
        end
    end

    // Observations recorded by apply_stimulus.
    bit [31:0]     grant_bits;
    int            n_grants;
    int            en_idx[$];
    int            ack_idx_c;
    int            stall_cnt, we_cnt, cack_cnt, lack_cnt;
    logic [DW-1:0] last_crd;
    logic [AW-1:0] en_addr;

    task automatic rand_cpu();
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = AW'($urandom_range(0, MSZ - 1));
        cpu_wdata = $urandom;
    endtask

    task automatic rand_ld();
        ld_we    = 1'($urandom_range(0, 1));
        ld_addr  = AW'($urandom_range(0, MSZ - 1));
        ld_wdata = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Called just after a rising edge. Each requester does the given number of accesses back to back.
    task automatic apply_stimulus(input int c_n, input int l_n, input int budget);
        int cl, ll;
        bit cdrop, ldrop;
        cl = c_n;
        ll = l_n;
        grant_bits = '0; n_grants = 0; en_idx.delete(); ack_idx_c = 0;
        stall_cnt = 0; we_cnt = 0; cack_cnt = 0; lack_cnt = 0; last_crd = '0; en_addr = '0;
        if (cl > 0) cpu_req = 1'b1;
        if (ll > 0) ld_req = 1'b1;
        for (int i = 1; i <= budget && (cl > 0 || ll > 0); i++) begin
            @(negedge clk);
            cdrop = 1'b0;
            ldrop = 1'b0;
            if (cpu_stall) stall_cnt++;
            if (mem_en) begin en_idx.push_back(i); en_addr = mem_addr; end
            if (mem_we) we_cnt++;
            if (cpu_ack) begin
                cack_cnt++; ack_idx_c = i; last_crd = cpu_rdata; n_grants++;
                if (cl > 0) cl--;
                cdrop = 1'b1;
            end
            if (ld_ack) begin
                lack_cnt++; grant_bits[n_grants] = 1'b1; n_grants++;
                if (ll > 0) ll--;
                ldrop = 1'b1;
            end
            @(posedge clk);
            #2;
            if (cdrop) begin if (cl > 0) rand_cpu(); else cpu_req = 1'b0; end
            if (ldrop) begin if (ll > 0) rand_ld(); else ld_req = 1'b0; end
        end
        cpu_req = 1'b0;
        ld_req = 1'b0;
        check_output("pending_after_run", cl + ll, 0);
    endtask

    initial begin
        int cnt_en, cnt_ack;
        logic [DW-1:0] v;
        for (int i = 0; i < MSZ; i++) begin
            v = $urandom;
            phys_mem[i] = v;
            ref_mem[i] = v;
        end
        phys_mem[16] = 32'hDEADBEEF;
        ref_mem[16]  = 32'hDEADBEEF;
        #1 chk_en = 1'b1;

        // Reset values
        idle(2);
        check_output("rst_busy", busy, 0);
        check_output("rst_mem_en", mem_en, 0);
        check_output("rst_mem_addr", mem_addr, 0);
        check_output("rst_cpu_ack", cpu_ack, 0);
        rst_n = 1'b1;
        idle(1);

        // CPU read of 0x10
        $display("[TB] CPU read of 0x10");
        cpu_we = 1'b0; cpu_addr = 32'h10;
        apply_stimulus(1, 0, 10);
        check_output("t1_ack_cnt", cack_cnt, 1);
        check_output("t1_ack_idx", ack_idx_c, 3);
        check_output("t1_en_cnt", en_idx.size(), 1);
        if (en_idx.size() > 0) check_output("t1_en_idx", en_idx[0], 2);
        check_output("t1_en_addr", en_addr, 32'h10);
        check_output("t1_rdata", last_crd, 32'hDEADBEEF);
        check_output("t1_stall_cnt", stall_cnt, 2);
        idle(1);

        // Loader write then CPU read of the same address
        $display("[TB] Loader write then CPU read");
        ld_we = 1'b1; ld_addr = 32'h20; ld_wdata = 32'h12345678;
        apply_stimulus(0, 1, 10);
        check_output("t2_we_cnt", we_cnt, 1);
        check_output("t2_ld_ack_cnt", lack_cnt, 1);
        cpu_we = 1'b0; cpu_addr = 32'h20;
        apply_stimulus(1, 0, 10);
        check_output("t2_rd_we_cnt", we_cnt, 0);
        check_output("t2_cpu_ack_cnt", cack_cnt, 1);
        check_output("t2_rdata", last_crd, 32'h12345678);
        idle(2);

        // Both held for 15 accesses
        $display("[TB] Contention pattern");
        rand_cpu(); rand_ld();
        apply_stimulus(12, 3, 60);
        check_output("t3_grant_cnt", n_grants, 15);
        check_output("t3_grant_order", grant_bits, 32'b100001000010000);
        if (en_idx.size() > 1) check_output("t3_spacing", en_idx[1] - en_idx[0], 3);
        idle(2);

        // Simultaneous single requests
        $display("[TB] Simultaneous single requests");
        rand_cpu(); rand_ld();
        apply_stimulus(1, 1, 20);
        check_output("t4_grant_order", grant_bits, 32'b10);
        check_output("t4_en_cnt", en_idx.size(), 2);
        if (en_idx.size() > 1) check_output("t4_en_gap", en_idx[1] - en_idx[0], 3);
        idle(2);

        // Reset during ISSUE of a CPU write
        $display("[TB] Reset during ISSUE");
        cpu_we = 1'b1; cpu_addr = 32'h5; cpu_wdata = $urandom; cpu_req = 1'b1;
        @(posedge clk); #2;
        check_output("t5_in_issue", mem_en, 1);
        rst_n = 1'b0;
        #1;
        check_output("t5_mem_en", mem_en, 0);
        check_output("t5_mem_we", mem_we, 0);
        check_output("t5_mem_addr", mem_addr, 0);
        check_output("t5_mem_wdata", mem_wdata, 0);
        check_output("t5_busy", busy, 0);
        repeat (2) begin
            @(negedge clk);
            check_output("t5_no_ack", cpu_ack, 0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        apply_stimulus(1, 0, 10);
        check_output("t5_reack_cnt", cack_cnt, 1);
        check_output("t5_reack_idx", ack_idx_c, 3);
        idle(2);

        // Requester drops req during ISSUE
        $display("[TB] Drop during ISSUE");
        cpu_we = 1'b0; cpu_addr = 32'h7; cpu_req = 1'b1;
        @(posedge clk); #2;
        cpu_req = 1'b0;
        cnt_en = 0; cnt_ack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_en) cnt_en++;
            if (cpu_ack) cnt_ack++;
        end
        check_output("t6_en_cnt", cnt_en, 1);
        check_output("t6_ack_cnt", cnt_ack, 1);
        check_output("t6_busy", busy, 0);
        @(posedge clk); #2;

        // Random bursts
        $display("[TB] Random bursts");
        for (int r = 0; r < 25; r++) begin
            idle($urandom_range(0, 3));
            rand_cpu(); rand_ld();
            apply_stimulus($urandom_range(0, 5), $urandom_range(0, 5), 80);
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
